// File: rtl/arf_op_sequencer.sv
// Multi-step op sequencer for the 8-bit address register file.
// Drives ARF selects and a req/ack memory port for FETCH/PUSH/POP/CALL/RET/JUMP/CLR.
module arf_op_sequencer #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [2:0] op_code,
  input  logic [7:0] op_data,
  output logic       done,
  output logic       err,
  output logic [7:0] result,
  output logic [1:0] arf_funsel,
  output logic [3:0] arf_rsel,
  output logic [1:0] arf_oasel,
  output logic [1:0] arf_obsel,
  output logic [7:0] arf_input,
  input  logic [7:0] arf_outa,
  input  logic [7:0] arf_outb,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_re,
  output logic       mem_we,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack
);

  typedef enum logic [4:0] {
    S_IDLE, S_F_MEM, S_F_INC,
    S_PU_MEM, S_PU_DEC,
    S_PO_INC, S_PO_MEM,
    S_CA_MEM, S_CA_DEC, S_CA_LD,
    S_RE_INC, S_RE_MEM, S_RE_LD,
    S_JU_PCP, S_JU_PC,
    S_CLR, S_DONE
  } state_e;

  localparam logic [3:0] TO_LAST = 4'(ACK_TIMEOUT - 1);

  localparam logic [1:0] FS_CLR = 2'b00;
  localparam logic [1:0] FS_LD  = 2'b01;
  localparam logic [1:0] FS_DEC = 2'b10;
  localparam logic [1:0] FS_INC = 2'b11;

  state_e     state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [7:0] result_q, result_d;
  logic       err_q, err_d;
  logic [3:0] cnt_q, cnt_d;
  logic       tmo;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      result_q <= result_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign tmo      = (cnt_q == TO_LAST);
  assign mem_addr = arf_outb;
  assign result   = result_q;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    result_d   = result_q;
    err_d      = err_q;
    cnt_d      = '0;
    op_ready   = (state_q == S_IDLE) & ~reset;
    done       = 1'b0;
    err        = 1'b0;
    arf_funsel = FS_CLR;
    arf_rsel   = 4'b0000;
    arf_oasel  = 2'b11;
    arf_obsel  = 2'b01;
    arf_input  = '0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          data_d = op_data;
          err_d  = 1'b0;
          unique case (op_code)
            3'b000: state_d = S_DONE;
            3'b001: state_d = S_F_MEM;
            3'b010: state_d = S_PU_MEM;
            3'b011: state_d = S_PO_INC;
            3'b100: state_d = S_CA_MEM;
            3'b101: state_d = S_RE_INC;
            3'b110: state_d = S_JU_PCP;
            3'b111: state_d = S_CLR;
          endcase
        end
      end
      // Memory steps: finish on ack, abort to DONE on timeout.
      S_F_MEM: begin
        arf_obsel = 2'b11;
        mem_re    = 1'b1;
        if (mem_ack) begin
          result_d = mem_rdata;
          state_d  = S_F_INC;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else cnt_d = cnt_q + 4'd1;
      end
      S_PU_MEM: begin
        mem_we    = 1'b1;
        mem_wdata = data_q;
        if (mem_ack) state_d = S_PU_DEC;
        else if (tmo) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else cnt_d = cnt_q + 4'd1;
      end
      S_PO_MEM: begin
        mem_re = 1'b1;
        if (mem_ack) begin
          result_d = mem_rdata;
          state_d  = S_DONE;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else cnt_d = cnt_q + 4'd1;
      end
      S_CA_MEM: begin
        mem_we    = 1'b1;
        mem_wdata = arf_outa;
        if (mem_ack) state_d = S_CA_DEC;
        else if (tmo) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else cnt_d = cnt_q + 4'd1;
      end
      S_RE_MEM: begin
        mem_re = 1'b1;
        if (mem_ack) begin
          data_d  = mem_rdata;
          state_d = S_RE_LD;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else cnt_d = cnt_q + 4'd1;
      end
      S_F_INC: begin
        arf_rsel   = 4'b1000;
        arf_funsel = FS_INC;
        state_d    = S_DONE;
      end
      S_PU_DEC, S_CA_DEC: begin
        arf_rsel   = 4'b0010;
        arf_funsel = FS_DEC;
        state_d    = (state_q == S_PU_DEC) ? S_DONE : S_CA_LD;
      end
      S_PO_INC, S_RE_INC: begin
        arf_rsel   = 4'b0010;
        arf_funsel = FS_INC;
        state_d    = (state_q == S_PO_INC) ? S_PO_MEM : S_RE_MEM;
      end
      S_CA_LD, S_RE_LD, S_JU_PC: begin
        arf_rsel   = 4'b1000;
        arf_funsel = FS_LD;
        arf_input  = data_q;
        state_d    = S_DONE;
      end
      S_JU_PCP: begin
        arf_rsel   = 4'b0001;
        arf_funsel = FS_LD;
        arf_input  = arf_outa;
        state_d    = S_JU_PC;
      end
      S_CLR: begin
        arf_rsel   = 4'b1111;
        arf_funsel = FS_CLR;
        state_d    = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        err     = err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_arf_op_sequencer.sv
// Directed bench for arf_op_sequencer with a behavioural ARF and
// a req/ack memory whose ack delay is programmable.
module tb_arf_op_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       op_valid;
  logic       op_ready;
  logic [2:0] op_code;
  logic [7:0] op_data;
  logic       done, err;
  logic [7:0] result;
  logic [1:0] arf_funsel, arf_oasel, arf_obsel;
  logic [3:0] arf_rsel;
  logic [7:0] arf_input, arf_outa, arf_outb;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_re, mem_we, mem_ack;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  arf_op_sequencer dut (
    .clock(clock), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_data(op_data),
    .done(done), .err(err), .result(result),
    .arf_funsel(arf_funsel), .arf_rsel(arf_rsel),
    .arf_oasel(arf_oasel), .arf_obsel(arf_obsel),
    .arf_input(arf_input),
    .arf_outa(arf_outa), .arf_outb(arf_outb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // Behavioural ARF with bench preset hooks
  logic [7:0] pc = 8'h00, ar = 8'h00, sp = 8'h00, pcp = 8'h00;
  logic       set_pc = 1'b0, set_sp = 1'b0;
  logic [7:0] set_v = 8'h00;

  function automatic logic [7:0] upd(input logic [7:0] r,
                                     input logic [1:0] fs,
                                     input logic [7:0] d);
    case (fs)
      2'b00:   return 8'h00;
      2'b01:   return d;
      2'b10:   return r - 8'd1;
      default: return r + 8'd1;
    endcase
  endfunction

  function automatic logic [7:0] rd_sel(input logic [1:0] s);
    case (s)
      2'b00:   return ar;
      2'b01:   return sp;
      2'b10:   return pcp;
      default: return pc;
    endcase
  endfunction

  always @(posedge clock) begin
    if (arf_rsel[3]) pc  <= upd(pc,  arf_funsel, arf_input);
    if (arf_rsel[2]) ar  <= upd(ar,  arf_funsel, arf_input);
    if (arf_rsel[1]) sp  <= upd(sp,  arf_funsel, arf_input);
    if (arf_rsel[0]) pcp <= upd(pcp, arf_funsel, arf_input);
    if (set_pc) pc <= set_v;
    if (set_sp) sp <= set_v;
  end

  assign arf_outa = rd_sel(arf_oasel);
  assign arf_outb = rd_sel(arf_obsel);

  // Memory with programmable ack latency
  logic [7:0] mem [256];
  logic       set_mem = 1'b0;
  logic [7:0] set_ma = 8'h00;
  logic       ack_en = 1'b1;
  int         ack_delay = 0;
  int         wcnt = 0;
  logic [7:0] last_rd = 8'h00;

  assign mem_ack   = (mem_re | mem_we) & ack_en & (wcnt == ack_delay);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clock) begin
    if (set_mem) mem[set_ma] <= set_v;
    else if (mem_we && mem_ack) mem[mem_addr] <= mem_wdata;
    if (mem_re && mem_ack) last_rd <= mem_addr;
    if (!(mem_re || mem_we) || mem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preset_pc(input logic [7:0] v);
    @(negedge clock); set_pc = 1'b1; set_v = v;
    @(posedge clock); #1 set_pc = 1'b0;
  endtask

  task automatic preset_sp(input logic [7:0] v);
    @(negedge clock); set_sp = 1'b1; set_v = v;
    @(posedge clock); #1 set_sp = 1'b0;
  endtask

  task automatic preset_mem(input logic [7:0] a, input logic [7:0] v);
    @(negedge clock); set_mem = 1'b1; set_ma = a; set_v = v;
    @(posedge clock); #1 set_mem = 1'b0;
  endtask

  int   lat, clr_cyc, we_cyc, re_cyc;
  logic err_seen;

  task automatic run_op(input logic [2:0] c, input logic [7:0] d);
    lat = 0; clr_cyc = 0; we_cyc = 0; re_cyc = 0; err_seen = 1'b0;
    @(negedge clock);
    chk("op_ready_idle", 32'(op_ready), 32'd1);
    op_valid = 1'b1; op_code = c; op_data = d;
    @(posedge clock); #1 op_valid = 1'b0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(negedge clock);
      if (arf_rsel == 4'hF && arf_funsel == 2'b00) clr_cyc++;
      if (mem_we) we_cyc++;
      if (mem_re) re_cyc++;
      if (done) begin
        lat = n;
        err_seen = err;
      end
    end
    if (lat == 0) chk("done_wait_bound", 32'd0, 32'd1);
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; op_code = 3'b000; op_data = 8'h00;
    #1;
    chk("rst_rsel",   32'(arf_rsel),   32'h0);
    chk("rst_funsel", 32'(arf_funsel), 32'h0);
    chk("rst_oasel",  32'(arf_oasel),  32'h3);
    chk("rst_obsel",  32'(arf_obsel),  32'h1);
    chk("rst_input",  32'(arf_input),  32'h0);
    chk("rst_req",    32'({mem_re, mem_we}), 32'h0);
    chk("rst_wdata",  32'(mem_wdata),  32'h0);
    chk("rst_done",   32'({done, err}), 32'h0);
    chk("rst_result", 32'(result),     32'h0);
    chk("rst_ready",  32'(op_ready),   32'h0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;

    // CLR
    preset_pc(8'h33);
    run_op(3'b111, 8'h00);
    chk("clr_lat",  32'(lat),     32'd2);
    chk("clr_cyc",  32'(clr_cyc), 32'd1);
    chk("clr_regs", 32'({pc, ar, sp, pcp}), 32'h0);

    // NOP
    run_op(3'b000, 8'h00);
    chk("nop_lat", 32'(lat), 32'd1);

    // FETCH with two wait cycles
    preset_pc(8'h10);
    preset_mem(8'h10, 8'hA5);
    ack_delay = 2;
    run_op(3'b001, 8'h00);
    chk("fetch_addr",   32'(last_rd), 32'h10);
    chk("fetch_result", 32'(result),  32'hA5);
    chk("fetch_pc",     32'(pc),      32'h11);
    chk("fetch_re_cyc", 32'(re_cyc),  32'd3);
    chk("fetch_lat",    32'(lat),     32'd5);
    ack_delay = 0;

    // FETCH with immediate ack
    preset_mem(8'h11, 8'h5A);
    run_op(3'b001, 8'h00);
    chk("fetch0_lat",    32'(lat),    32'd3);
    chk("fetch0_result", 32'(result), 32'h5A);
    chk("fetch0_pc",     32'(pc),     32'h12);

    // PUSH / POP
    preset_sp(8'hFF);
    run_op(3'b010, 8'h3C);
    chk("push_mem", 32'(mem[8'hFF]), 32'h3C);
    chk("push_sp",  32'(sp),         32'hFE);
    chk("push_lat", 32'(lat),        32'd3);
    chk("push_err", 32'(err_seen),   32'd0);
    run_op(3'b011, 8'h00);
    chk("pop_addr",   32'(last_rd), 32'hFF);
    chk("pop_result", 32'(result),  32'h3C);
    chk("pop_sp",     32'(sp),      32'hFF);

    // CALL / RET
    preset_pc(8'h12);
    preset_sp(8'h80);
    run_op(3'b100, 8'h40);
    chk("call_mem", 32'(mem[8'h80]), 32'h12);
    chk("call_sp",  32'(sp),         32'h7F);
    chk("call_pc",  32'(pc),         32'h40);
    chk("call_lat", 32'(lat),        32'd4);
    run_op(3'b101, 8'h00);
    chk("ret_pc",     32'(pc),     32'h12);
    chk("ret_sp",     32'(sp),     32'h80);
    chk("ret_lat",    32'(lat),    32'd4);
    chk("ret_result", 32'(result), 32'h3C);

    // JUMP, then PUSH wrapping SP
    preset_pc(8'h05);
    run_op(3'b110, 8'h20);
    chk("jump_pcp", 32'(pcp), 32'h05);
    chk("jump_pc",  32'(pc),  32'h20);
    chk("jump_lat", 32'(lat), 32'd3);
    preset_sp(8'h00);
    run_op(3'b010, 8'h77);
    chk("wrap_sp",  32'(sp),         32'hFF);
    chk("wrap_mem", 32'(mem[8'h00]), 32'h77);

    // Timeout on PUSH
    ack_en = 1'b0;
    run_op(3'b010, 8'h99);
    chk("tmo_err",    32'(err_seen),   32'd1);
    chk("tmo_we_cyc", 32'(we_cyc),     32'd15);
    chk("tmo_lat",    32'(lat),        32'd16);
    chk("tmo_sp",     32'(sp),         32'hFF);
    chk("tmo_mem",    32'(mem[8'hFF]), 32'h3C);
    ack_en = 1'b1;
    run_op(3'b000, 8'h00);
    chk("post_tmo_err", 32'(err_seen), 32'd0);

    // Reset in the middle of a memory step
    ack_en = 1'b0;
    @(negedge clock);
    op_valid = 1'b1; op_code = 3'b010; op_data = 8'h11;
    @(posedge clock); #1 op_valid = 1'b0;
    @(negedge clock);
    chk("mid_we", 32'(mem_we), 32'd1);
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    #1;
    chk("mid_rst_we",    32'(mem_we),   32'd0);
    chk("mid_rst_ready", 32'(op_ready), 32'd0);
    chk("mid_rst_res",   32'(result),   32'h0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("mid_rel_ready", 32'(op_ready), 32'd1);
    ack_en = 1'b1;
    run_op(3'b000, 8'h00);
    chk("post_rst_nop", 32'(lat), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
